// File: rtl/mem_stage_if.sv
// Data-memory request/response bus: mem_stage drives it as master, the data memory answers as slave.
// Also provides the EX/MEM control-bit layout when no pipeline-wide header is present.
`ifndef CONTROL_SIGNALS_WIDTH
`define CONTROL_SIGNALS_WIDTH 4
`define CTRL_REG_WRITE  0
`define CTRL_MEM_READ   1
`define CTRL_MEM_WRITE  2
`define CTRL_MEM_TO_REG 3
`endif

interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Fourth pipeline stage: data-memory load/store over a waitable handshake, then the MEM/WB register.
// Stalls upstream while an access is outstanding; faults and timeouts retire as a one-cycle mem_exc.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [31:0]                       ex_mem_pc,
    input  logic [31:0]                       ex_mem_alu_result,
    input  logic [31:0]                       ex_mem_rs2_data,
    input  logic [4:0]                        ex_mem_rd_addr,
    input  logic [2:0]                        ex_mem_funct3,
    input  logic [`CONTROL_SIGNALS_WIDTH-1:0] ex_mem_control_signals,
    input  logic                              ex_mem_valid,
    mem_stage_if.master                       dmem,
    output logic                              mem_stall,
    output logic [31:0]                       mem_wb_pc,
    output logic [31:0]                       mem_wb_alu_result,
    output logic [31:0]                       mem_wb_mem_data,
    output logic [4:0]                        mem_wb_rd_addr,
    output logic                              mem_wb_reg_write,
    output logic                              mem_wb_mem_to_reg,
    output logic                              mem_wb_valid,
    output logic                              mem_exc
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      mem_wb_pc_q, mem_wb_pc_d;
    logic [31:0]      mem_wb_alu_result_q, mem_wb_alu_result_d;
    logic [31:0]      mem_wb_mem_data_q, mem_wb_mem_data_d;
    logic [4:0]       mem_wb_rd_addr_q, mem_wb_rd_addr_d;
    logic             mem_wb_reg_write_q, mem_wb_reg_write_d;
    logic             mem_wb_mem_to_reg_q, mem_wb_mem_to_reg_d;
    logic             mem_wb_valid_q, mem_wb_valid_d;
    logic             mem_exc_q, mem_exc_d;

    logic        is_store, is_load, access;
    logic        f3_bad, align_bad, fault, timeout_hit, eff_fault, req;
    logic [1:0]  lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // A set WRITE bit wins, so READ|WRITE is treated as a store.
    assign is_store = ex_mem_valid & ex_mem_control_signals[`CTRL_MEM_WRITE];
    assign is_load  = ex_mem_valid & ex_mem_control_signals[`CTRL_MEM_READ]
                                   & ~ex_mem_control_signals[`CTRL_MEM_WRITE];
    assign access   = is_store | is_load;
    assign lane     = ex_mem_alu_result[1:0];

    // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        f3_bad    = 1'b0;
        align_bad = 1'b0;
        if (is_store) f3_bad = !(ex_mem_funct3 inside {3'b000, 3'b001, 3'b010});
        else          f3_bad = !(ex_mem_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        case (ex_mem_funct3[1:0])
            2'b01:   align_bad = lane[0];
            2'b10:   align_bad = (lane != 2'b00);
            default: align_bad = 1'b0;
        endcase
        fault = access & (f3_bad | align_bad);
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == S_WAIT) && (cnt_q >= CNT_LIMIT);
    assign eff_fault   = fault | timeout_hit;
    assign req         = (state_q == S_IDLE) ? (access & ~fault) : ~timeout_hit;

    // Reset gates the request directly so an in-flight WAIT cannot leak a request through reset.
    assign dmem.dmem_req   = reset & req;
    assign dmem.dmem_we    = is_store;
    assign dmem.dmem_addr  = {ex_mem_alu_result[31:2], 2'b00};
    assign mem_stall       = dmem.dmem_req & ~dmem.dmem_ready;

    always_comb begin
        dmem.dmem_wstrb = 4'b0000;
        dmem.dmem_wdata = ex_mem_rs2_data;
        case (ex_mem_funct3[1:0])
            2'b00: begin
                dmem.dmem_wstrb = 4'b0001 << lane;
                dmem.dmem_wdata = {4{ex_mem_rs2_data[7:0]}};
            end
            2'b01: begin
                dmem.dmem_wstrb = 4'b0011 << lane;
                dmem.dmem_wdata = {2{ex_mem_rs2_data[15:0]}};
            end
            default: dmem.dmem_wstrb = 4'hF;
        endcase
        if (!is_store) dmem.dmem_wstrb = 4'b0000;
    end

    always_comb begin
        ld_byte = dmem.dmem_rdata[{lane, 3'b000} +: 8];
        ld_half = lane[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (ex_mem_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h000000, ld_byte};
            3'b101:  ld_data = {16'h0000, ld_half};
            default: ld_data = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (req && !dmem.dmem_ready) begin
                state_d = S_WAIT;
                cnt_d   = CNT_W'(1);
            end
            S_WAIT: if (timeout_hit || dmem.dmem_ready) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A stalled cycle inserts a bubble: valid and write-enable drop, the payload fields hold.
    always_comb begin
        mem_wb_pc_d         = mem_wb_pc_q;
        mem_wb_alu_result_d = mem_wb_alu_result_q;
        mem_wb_mem_data_d   = mem_wb_mem_data_q;
        mem_wb_rd_addr_d    = mem_wb_rd_addr_q;
        mem_wb_mem_to_reg_d = mem_wb_mem_to_reg_q;
        mem_wb_valid_d      = 1'b0;
        mem_wb_reg_write_d  = 1'b0;
        mem_exc_d           = 1'b0;
        if (!mem_stall) begin
            mem_wb_pc_d         = ex_mem_pc;
            mem_wb_alu_result_d = ex_mem_alu_result;
            mem_wb_rd_addr_d    = ex_mem_rd_addr;
            mem_wb_mem_to_reg_d = ex_mem_control_signals[`CTRL_MEM_TO_REG];
            mem_wb_mem_data_d   = (is_load && !eff_fault) ? ld_data : 32'h0;
            mem_wb_valid_d      = ex_mem_valid & ~eff_fault;
            mem_wb_reg_write_d  = ex_mem_valid & ex_mem_control_signals[`CTRL_REG_WRITE]
                                & ~eff_fault & (ex_mem_rd_addr != 5'd0);
            mem_exc_d           = ex_mem_valid & eff_fault;
        end
    end

    // NOTE: state uses non-blocking assignment so every flop samples the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q             <= S_IDLE;
            cnt_q               <= '0;
            mem_wb_pc_q         <= '0;
            mem_wb_alu_result_q <= '0;
            mem_wb_mem_data_q   <= '0;
            mem_wb_rd_addr_q    <= '0;
            mem_wb_reg_write_q  <= 1'b0;
            mem_wb_mem_to_reg_q <= 1'b0;
            mem_wb_valid_q      <= 1'b0;
            mem_exc_q           <= 1'b0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            mem_wb_pc_q         <= mem_wb_pc_d;
            mem_wb_alu_result_q <= mem_wb_alu_result_d;
            mem_wb_mem_data_q   <= mem_wb_mem_data_d;
            mem_wb_rd_addr_q    <= mem_wb_rd_addr_d;
            mem_wb_reg_write_q  <= mem_wb_reg_write_d;
            mem_wb_mem_to_reg_q <= mem_wb_mem_to_reg_d;
            mem_wb_valid_q      <= mem_wb_valid_d;
            mem_exc_q           <= mem_exc_d;
        end
    end

    assign mem_wb_pc         = mem_wb_pc_q;
    assign mem_wb_alu_result = mem_wb_alu_result_q;
    assign mem_wb_mem_data   = mem_wb_mem_data_q;
    assign mem_wb_rd_addr    = mem_wb_rd_addr_q;
    assign mem_wb_reg_write  = mem_wb_reg_write_q;
    assign mem_wb_mem_to_reg = mem_wb_mem_to_reg_q;
    assign mem_wb_valid      = mem_wb_valid_q;
    assign mem_exc           = mem_exc_q;
endmodule
